// File: rtl/filtro_iir_biquad.sv
// Direct-form-I biquad IIR filter with one shared multiplier, 7 cycles per sample.
// Define FILTRO_SATURACION_EN to clamp the output instead of wrapping it.
module filtro_iir_biquad #(
    parameter int N = 25,
    parameter int F = 15
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] Uk,
    input  logic         Bandera_ADC,
    input  logic         Limpiar,
    input  logic [N-1:0] B0,
    input  logic [N-1:0] B1,
    input  logic [N-1:0] B2,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    output logic [N-1:0] Yk,
    output logic         Bandera_Listo,
    output logic         Ocupado,
    output logic         Perdida
);

    localparam int AW = 2 * N + 3;
    localparam logic signed [AW-1:0] Half = {{(AW-1){1'b0}}, 1'b1} << (F - 1);

    typedef enum logic [1:0] {StIdle, StMac, StFin} state_t;

    state_t                 state_q;
    logic [2:0]             idx_q;
    logic signed [N-1:0]    u0_q, u1_q, u2_q, y1_q, y2_q;
    logic signed [AW-1:0]   acc_q;

    logic signed [N-1:0]    coef, op;
    logic signed [2*N-1:0]  prod;
    logic signed [AW-1:0]   prod_ext, acc_next, rounded, shifted;
    logic signed [N-1:0]    result;

    always_comb begin
        coef = '0;
        op   = '0;
        case (idx_q)
            3'd0: begin coef = $signed(B0); op = u0_q; end
            3'd1: begin coef = $signed(B1); op = u1_q; end
            3'd2: begin coef = $signed(B2); op = u2_q; end
            3'd3: begin coef = $signed(A1); op = y1_q; end
            3'd4: begin coef = $signed(A2); op = y2_q; end
            default: begin coef = '0; op = '0; end
        endcase
        prod     = coef * op;
        prod_ext = {{3{prod[2*N-1]}}, prod};
        // Feedback products (A1, A2) are subtracted.
        acc_next = (idx_q >= 3'd3) ? (acc_q - prod_ext) : (acc_q + prod_ext);
        rounded  = acc_q + Half;
        shifted  = rounded >>> F;
    end

`ifdef FILTRO_SATURACION_EN
    localparam logic signed [AW-1:0] MaxV = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] MinV = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

    always_comb begin
        if (shifted > MaxV) begin
            result = {1'b0, {(N-1){1'b1}}};
        end else if (shifted < MinV) begin
            result = {1'b1, {(N-1){1'b0}}};
        end else begin
            result = shifted[N-1:0];
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shifted[AW-1:N];

    always_comb begin
        result = shifted[N-1:0];
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            acc_q         <= '0;
            u0_q          <= '0;
            u1_q          <= '0;
            u2_q          <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            Yk            <= '0;
            Bandera_Listo <= 1'b0;
            Ocupado       <= 1'b0;
            Perdida       <= 1'b0;
        end else begin
            Bandera_Listo <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (Limpiar) begin
                        u1_q    <= '0;
                        u2_q    <= '0;
                        y1_q    <= '0;
                        y2_q    <= '0;
                        Yk      <= '0;
                        Perdida <= 1'b0;
                    end
                    if (Bandera_ADC) begin
                        u0_q    <= $signed(Uk);
                        acc_q   <= '0;
                        idx_q   <= '0;
                        Ocupado <= 1'b1;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    if (Bandera_ADC) Perdida <= 1'b1;
                    acc_q <= acc_next;
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd4) state_q <= StFin;
                end
                StFin: begin
                    if (Bandera_ADC) Perdida <= 1'b1;
                    Yk            <= result;
                    y1_q          <= result;
                    y2_q          <= y1_q;
                    u1_q          <= u0_q;
                    u2_q          <= u1_q;
                    Bandera_Listo <= 1'b1;
                    Ocupado       <= 1'b0;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_filtro_iir_biquad.sv
// Directed bench for filtro_iir_biquad: table of samples plus hand-written corner sequences.
// Expected overflow results follow FILTRO_SATURACION_EN.
module tb_filtro_iir_biquad;

    localparam int N = 25;
    localparam int F = 15;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [N-1:0] Uk;
    logic         Bandera_ADC;
    logic         Limpiar;
    logic [N-1:0] B0, B1, B2, A1, A2;
    logic [N-1:0] Yk;
    logic         Bandera_Listo;
    logic         Ocupado;
    logic         Perdida;

    int checks = 0;
    int passes = 0;

    filtro_iir_biquad #(.N(N), .F(F)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Uk            (Uk),
        .Bandera_ADC   (Bandera_ADC),
        .Limpiar       (Limpiar),
        .B0            (B0),
        .B1            (B1),
        .B2            (B2),
        .A1            (A1),
        .A2            (A2),
        .Yk            (Yk),
        .Bandera_Listo (Bandera_Listo),
        .Ocupado       (Ocupado),
        .Perdida       (Perdida)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic clr;
        int   b0, b1, b2, a1, a2;
        int   u;
        int   y;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_coefs(input int b0, input int b1, input int b2, input int a1,
                             input int a2);
        B0 = b0[N-1:0];
        B1 = b1[N-1:0];
        B2 = b2[N-1:0];
        A1 = a1[N-1:0];
        A2 = a2[N-1:0];
    endtask

    task automatic clear_hist();
        Limpiar = 1'b1;
        step();
        Limpiar = 1'b0;
    endtask

    // Strobe one sample; returns just after capture edge E0.
    task automatic strobe(input int u);
        Uk = u[N-1:0];
        Bandera_ADC = 1'b1;
        step();
        Bandera_ADC = 1'b0;
    endtask

    // Counts edges until Bandera_Listo is seen, bounded.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (Bandera_Listo !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;

        vecs[0]  = '{1'b1, 32768, 0, 0, 0, 0, 1000, 1000};
        vecs[1]  = '{1'b1, 32768, 0, 0, 0, 0, -1000, -1000};
        vecs[2]  = '{1'b1, 16384, 0, 0, -16384, 0, 1000, 500};
        vecs[3]  = '{1'b0, 16384, 0, 0, -16384, 0, 1000, 750};
        vecs[4]  = '{1'b0, 16384, 0, 0, -16384, 0, 1000, 875};
        vecs[5]  = '{1'b0, 16384, 0, 0, -16384, 0, 1000, 938};
        vecs[6]  = '{1'b1, 16384, 0, 0, 0, 0, 3, 2};
        vecs[7]  = '{1'b1, 16384, 0, 0, 0, 0, -3, -1};
        vecs[8]  = '{1'b1, 0, 32768, 16384, 0, 0, 7, 0};
        vecs[9]  = '{1'b0, 0, 32768, 16384, 0, 0, 9, 7};
        vecs[10] = '{1'b0, 0, 32768, 16384, 0, 0, 11, 13};
        vecs[11] = '{1'b1, 32768, 0, 0, 0, 16384, 100, 100};
        vecs[12] = '{1'b0, 32768, 0, 0, 0, 16384, 100, 100};
        vecs[13] = '{1'b0, 32768, 0, 0, 0, 16384, 100, 50};
        vecs[14] = '{1'b1, 32768, 32768, 32768, 0, 0, 16777215, 16777215};
`ifdef FILTRO_SATURACION_EN
        vecs[15] = '{1'b0, 32768, 32768, 32768, 0, 0, 16777215, 16777215};
        vecs[16] = '{1'b0, 32768, 32768, 32768, 0, 0, 16777215, 16777215};
`else
        vecs[15] = '{1'b0, 32768, 32768, 32768, 0, 0, 16777215, -2};
        vecs[16] = '{1'b0, 32768, 32768, 32768, 0, 0, 16777215, 16777213};
`endif

        Reset_n = 1'b0;
        Uk = '0;
        Bandera_ADC = 1'b0;
        Limpiar = 1'b0;
        set_coefs(0, 0, 0, 0, 0);
        #12;
        chk("reset_yk", $signed(Yk), 0);
        chk("reset_listo", Bandera_Listo, 0);
        chk("reset_ocupado", Ocupado, 0);
        chk("reset_perdida", Perdida, 0);
        Reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            if (vecs[i].clr) clear_hist();
            set_coefs(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].a1, vecs[i].a2);
            strobe(vecs[i].u);
            if (i == 0) chk("ocupado_mac", Ocupado, 1);
            wait_done(0, lat);
            chk($sformatf("latency[%0d]", i), lat, 6);
            chk($sformatf("yk[%0d]", i), $signed(Yk), vecs[i].y);
            step();
            if (i < 2) begin
                chk($sformatf("pulse_width[%0d]", i), Bandera_Listo, 0);
                chk($sformatf("ocupado_idle[%0d]", i), Ocupado, 0);
            end
        end

        // Dropped sample: second strobe two cycles after the first.
        clear_hist();
        chk("clear_yk", $signed(Yk), 0);
        set_coefs(32768, 0, 0, 0, 0);
        strobe(1000);
        step();
        strobe(5000);
        wait_done(2, lat);
        chk("drop_latency", lat, 6);
        chk("drop_yk", $signed(Yk), 1000);
        chk("drop_perdida", Perdida, 1);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (Bandera_Listo) pulses++;
        end
        chk("drop_extra_pulses", pulses, 0);
        chk("drop_perdida_sticky", Perdida, 1);
        clear_hist();
        chk("limpiar_perdida", Perdida, 0);
        chk("limpiar_yk", $signed(Yk), 0);

        // Limpiar during MAC is ignored.
        set_coefs(16384, 0, 0, -16384, 0);
        strobe(1000);
        wait_done(0, lat);
        step();
        strobe(1000);
        Limpiar = 1'b1;
        step();
        step();
        Limpiar = 1'b0;
        wait_done(2, lat);
        chk("limpiar_mac_yk", $signed(Yk), 750);
        step();

        // Coefficient change after product 0 applies only to later products.
        clear_hist();
        set_coefs(32768, 0, 0, 0, 0);
        strobe(100);
        wait_done(0, lat);
        step();
        strobe(200);
        step();
        set_coefs(0, 32768, 0, 0, 0);
        wait_done(1, lat);
        chk("coef_change_yk", $signed(Yk), 300);
        step();

        // Reset during MAC product 3.
        clear_hist();
        set_coefs(16384, 0, 0, -16384, 0);
        strobe(1000);
        wait_done(0, lat);
        step();
        strobe(1000);
        step();
        step();
        step();
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_yk", $signed(Yk), 0);
        chk("rst_mid_ocupado", Ocupado, 0);
        #3;
        Reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (Bandera_Listo) pulses++;
        end
        chk("rst_mid_pulses", pulses, 0);
        strobe(1000);
        wait_done(0, lat);
        chk("rst_fresh_latency", lat, 6);
        chk("rst_fresh_yk", $signed(Yk), 500);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
